// File: rtl/mips_muldiv_pkg.sv
// mips_muldiv_pkg: shared R-type funct-field codes and opcode classification helpers
package mips_muldiv_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    function automatic logic is_iter_op(input logic [5:0] op);
        return op == FUNCT_MULT || op == FUNCT_MULTU || op == FUNCT_DIV || op == FUNCT_DIVU;
    endfunction

    function automatic logic is_hilo_op(input logic [5:0] op);
        return is_iter_op(op) || op == FUNCT_MFHI || op == FUNCT_MTHI || op == FUNCT_MFLO || op == FUNCT_MTLO;
    endfunction

endpackage

// File: rtl/mips_div_core.sv
// mips_div_core: iterative unsigned restoring divider, one quotient bit per cycle
module mips_div_core #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              valid
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    logic [DATA_W-1:0] dvs;
    logic [CNT_W-1:0]  cnt;
    logic              running;
    logic [DATA_W:0]   shifted;
    logic              ge;
    logic [DATA_W-1:0] sub;

    // when the partial remainder is at least the divisor the true difference fits in DATA_W bits
    always_comb begin
        shifted = {remainder, quotient[DATA_W-1]};
        ge      = shifted >= {1'b0, dvs};
        sub     = shifted[DATA_W-1:0] - dvs;
    end

    // quotient register doubles as the dividend shift register
    always_ff @(posedge clk) begin
        if (reset) begin
            quotient  <= '0;
            remainder <= '0;
            dvs       <= '0;
            cnt       <= '0;
            running   <= 1'b0;
            valid     <= 1'b0;
        end else if (start) begin
            quotient  <= dividend;
            remainder <= '0;
            dvs       <= divisor;
            cnt       <= '0;
            running   <= 1'b1;
            valid     <= 1'b0;
        end else if (running) begin
            quotient  <= {quotient[DATA_W-2:0], ge};
            remainder <= ge ? sub : shifted[DATA_W-1:0];
            cnt       <= cnt + 1'b1;
            if (cnt == CNT_W'(DATA_W - 1)) begin
                running <= 1'b0;
                valid   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mips_muldiv.sv
// mips_muldiv: MIPS HI/LO multiply/divide unit; define MULDIV_FAST_MUL_EN for a single-cycle multiplier
module mips_muldiv
    import mips_muldiv_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [5:0]        alu_opcode_i,
    input  logic [DATA_W-1:0] rs_i,
    input  logic [DATA_W-1:0] rt_i,
    output logic              stall_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   mcand;
    logic [DATA_W-1:0]   rs_raw;
    logic [2*DATA_W-1:0] prod;
    logic                is_div;
    logic                neg_a;
    logic                neg_b;
    logic                div_zero;
    logic                accept;
    logic                is_signed;
    logic                a_neg;
    logic                b_neg;
    logic [DATA_W-1:0]   a_abs;
    logic [DATA_W-1:0]   b_abs;
    logic                div_start;
    logic [DATA_W:0]     add_sum;
    logic [DATA_W-1:0]   quo;
    logic [DATA_W-1:0]   rem;
    logic                div_valid;

    // issue decode, operand magnitudes and the multiply partial-sum adder
    always_comb begin
        accept    = start_i && !busy_o && is_iter_op(alu_opcode_i);
        is_signed = alu_opcode_i == FUNCT_MULT || alu_opcode_i == FUNCT_DIV;
        a_neg     = is_signed && rs_i[DATA_W-1];
        b_neg     = is_signed && rt_i[DATA_W-1];
        a_abs     = a_neg ? -rs_i : rs_i;
        b_abs     = b_neg ? -rt_i : rt_i;
        div_start = accept && (alu_opcode_i == FUNCT_DIV || alu_opcode_i == FUNCT_DIVU);
        stall_o   = start_i && busy_o && is_hilo_op(alu_opcode_i);
        result_o  = !start_i ? '0 :
                    alu_opcode_i == FUNCT_MFHI ? hi_o :
                    alu_opcode_i == FUNCT_MFLO ? lo_o : '0;
        add_sum   = {1'b0, prod[2*DATA_W-1:DATA_W]} + (prod[0] ? {1'b0, mcand} : '0);
    end

    mips_div_core #(.DATA_W(DATA_W)) u_div (
        .clk       (clk_i),
        .reset     (reset_i),
        .start     (div_start),
        .dividend  (a_abs),
        .divisor   (b_abs),
        .quotient  (quo),
        .remainder (rem),
        .valid     (div_valid)
    );

    // IDLE/RUN/FIX sequencer owning HI/LO, the multiply shift register and the status flags
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state    <= IDLE;
            cnt      <= '0;
            hi_o     <= '0;
            lo_o     <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            mcand    <= '0;
            rs_raw   <= '0;
            prod     <= '0;
            is_div   <= 1'b0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= RUN;
                        busy_o   <= 1'b1;
                        cnt      <= '0;
                        prod     <= {{DATA_W{1'b0}}, b_abs};
                        mcand    <= a_abs;
                        rs_raw   <= rs_i;
                        is_div   <= div_start;
                        neg_a    <= a_neg;
                        neg_b    <= b_neg;
                        div_zero <= rt_i == '0;
                    end else if (start_i && alu_opcode_i == FUNCT_MTHI) begin
                        hi_o <= rs_i;
                    end else if (start_i && alu_opcode_i == FUNCT_MTLO) begin
                        lo_o <= rs_i;
                    end
                end
                RUN: begin
                    cnt  <= cnt + 1'b1;
                    prod <= {add_sum, prod[DATA_W-1:1]};
                    if (cnt == CNT_W'(DATA_W - 1)) state <= FIX;
`ifdef MULDIV_FAST_MUL_EN
                    if (!is_div) begin
                        prod  <= {{DATA_W{1'b0}}, mcand} * prod;
                        state <= FIX;
                    end
`endif
                end
                FIX: begin
                    if (!is_div || div_valid) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        if (!is_div) begin
                            {hi_o, lo_o} <= (neg_a ^ neg_b) ? -prod : prod;
                        end else if (div_zero) begin
                            hi_o <= rs_raw;
                            lo_o <= '1;
                        end else begin
                            hi_o <= neg_a ? -rem : rem;
                            lo_o <= (neg_a ^ neg_b) ? -quo : quo;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv.sv
// tb_mips_muldiv: randomized scoreboard bench for mips_muldiv against a plain-arithmetic HI/LO model
module tb_mips_muldiv;
    import mips_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  opc;
    logic [31:0] rs, rt;
    logic        stall_o, busy_o, done_o;
    logic [31:0] result_o, hi_o, lo_o;

    always #5 clk = ~clk;

    mips_muldiv #(.DATA_W(32)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .start_i      (start),
        .alu_opcode_i (opc),
        .rs_i         (rs),
        .rt_i         (rt),
        .stall_o      (stall_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .result_o     (result_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_hi = '0, m_lo = '0;
    int          n_chk = 0, n_fail = 0;
    int          bcnt = 0, last_busy = 0, n_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        x = $signed(a);
        y = $signed(b);
        if (op == FUNCT_MULT) return x * y;
        if (op == FUNCT_MULTU) return {32'b0, a} * {32'b0, b};
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (op == FUNCT_DIVU) return {a % b, a / b};
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int latency(input logic [5:0] op);
`ifdef MULDIV_FAST_MUL_EN
        if (op == FUNCT_MULT || op == FUNCT_MULTU) return 2;
`endif
        return 33;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 4))
            0: return $urandom;
            1: return $urandom_range(0, 15);
            2: return 32'h0;
            3: return 32'h8000_0000;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // monitor: measure busy length and score every done pulse against the queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (busy_o) bcnt++;
        else if (bcnt != 0) begin
            last_busy = bcnt;
            bcnt = 0;
        end
        if (done_o) begin
            n_done++;
            if (sb.size() == 0) check("unexpected_done", 1, 0);
            else begin
                e = sb.pop_front();
                check("hi", hi_o, e.hi);
                check("lo", lo_o, e.lo);
                check("busy_cycles", last_busy, e.lat);
            end
        end
    end

    // present an op, hold it while stalled, update the model and check result_o at acceptance
    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int stalls, output logic done_at_acc);
        logic [63:0] r;
        @(negedge clk);
        start = 1'b1; opc = op; rs = a; rt = b; stalls = 0;
        #1;
        while (stall_o && stalls < 200) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        if (stalls >= 200) check("stall_timeout", 1, 0);
        done_at_acc = done_o;
        if (op == FUNCT_MFHI) check("mfhi_result", result_o, m_hi);
        else if (op == FUNCT_MFLO) check("mflo_result", result_o, m_lo);
        else check("result_zero", result_o, 0);
        if (is_iter_op(op)) begin
            r = ref_op(op, a, b);
            {m_hi, m_lo} = r;
            sb.push_back('{r[63:32], r[31:0], latency(op)});
        end else if (op == FUNCT_MTHI) m_hi = a;
        else if (op == FUNCT_MTLO) m_lo = a;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("drain_timeout", 1, 0);
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a, b, ehi, elo;
    } dir_t;

    dir_t dirs[6] = '{
        '{FUNCT_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA},
        '{FUNCT_MULTU, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'hFFFF_FFFA},
        '{FUNCT_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD},
        '{FUNCT_DIVU,  32'd7,         32'd2,        32'd1,         32'd3},
        '{FUNCT_DIV,   32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF},
        '{FUNCT_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000}
    };

    logic [5:0] ops[9] = '{FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO,
                           FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, 6'h21};

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   st, nd;
        logic da;
        reset = 1'b1; start = 1'b0; opc = '0; rs = '0; rt = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy_o, 0);
        check("reset_done", done_o, 0);
        check("reset_hi", hi_o, 0);
        check("reset_lo", lo_o, 0);
        check("reset_stall", stall_o, 0);
        reset = 1'b0;

        foreach (dirs[i]) begin
            issue(dirs[i].op, dirs[i].a, dirs[i].b, st, da);
            drain();
            check("dir_hi", hi_o, dirs[i].ehi);
            check("dir_lo", lo_o, dirs[i].elo);
        end

        issue(FUNCT_DIVU, 32'd100, 32'd7, st, da);
        repeat (4) @(posedge clk);
        issue(FUNCT_MFLO, 32'd0, 32'd0, st, da);
        check("mflo_stalled", st > 0, 1);
        check("mflo_accept_after_fix", da, 1);
        check("mflo_14", m_lo, 14);

        issue(FUNCT_MULTU, $urandom, $urandom, st, da);
        @(negedge clk);
        start = 1'b1; opc = 6'h2A; rs = 32'h1111_1111;
        #1;
        check("illegal_no_stall", stall_o, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();
        @(negedge clk);
        check("illegal_hi_kept", hi_o, m_hi);
        issue(6'h3F, 32'h2222_2222, 32'h0, st, da);
        check("illegal_idle_no_stall", st, 0);
        @(negedge clk);
        check("illegal_idle_lo_kept", lo_o, m_lo);

        issue(FUNCT_MTHI, 32'hDEAD_BEEF, 32'h0, st, da);
        @(negedge clk);
        check("mthi", hi_o, 32'hDEAD_BEEF);
        issue(FUNCT_MFHI, 32'h0, 32'h0, st, da);
        check("mfhi_no_stall", st, 0);

        for (int i = 0; i < 60; i++) begin
            issue(ops[$urandom_range(0, 8)], rand_operand(), rand_operand(), st, da);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 40)) @(posedge clk);
        end
        drain();

        issue(FUNCT_DIV, 32'd1000, 32'd3, st, da);
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        m_hi = '0;
        m_lo = '0;
        nd = n_done;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", busy_o, 0);
        check("abort_hi", hi_o, 0);
        check("abort_lo", lo_o, 0);
        repeat (40) @(negedge clk);
        check("abort_no_done", n_done, nd);
        check("queue_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
